// File: rtl/la_axis_arb_if.sv
// AXI-Stream bundle used for the user, logic-analyzer and merged ports of la_axis_arb.
interface la_axis_arb_if #(
  parameter int unsigned pDATA_WIDTH = 32
);
  logic [pDATA_WIDTH-1:0] tdata;
  logic [3:0]             tstrb;
  logic [3:0]             tkeep;
  logic [1:0]             tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  // Stream producer: drives payload and valid, receives ready.
  modport master (output tdata, tstrb, tkeep, tuser, tlast, tvalid, input tready);
  // Stream consumer: receives payload and valid, drives ready.
  modport slave  (input tdata, tstrb, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/la_axis_arb.sv
// Packet-granular two-source AXI-Stream arbiter merging the user-project and
// logic-analyzer streams, with LA high-priority preemption bounded by a starvation limit.
module la_axis_arb #(
  parameter int unsigned pDATA_WIDTH    = 32,
  parameter int unsigned pMAX_HPRI_PKTS = 4
) (
  input  logic        axis_clk,
  input  logic        axis_rst,
  input  logic        arb_en,
  input  logic        la_hpri_req,
  la_axis_arb_if.slave  up,
  la_axis_arb_if.slave  la,
  la_axis_arb_if.master m,
  output logic [1:0]  grant,
  output logic [15:0] up_pkt_cnt,
  output logic [15:0] la_pkt_cnt
);

  localparam int unsigned STARVE_W = $clog2(pMAX_HPRI_PKTS) + 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(pMAX_HPRI_PKTS);
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_UP = 2'b01,
    GNT_LA = 2'b10
  } state_t;

  state_t              r_state;
  logic [1:0]          r_grant;
  logic                r_last_la;
  logic                r_hpri_gnt;
  logic [STARVE_W-1:0] r_starve;
  logic [15:0]         r_up_cnt;
  logic [15:0]         r_la_cnt;

  logic w_up_done;
  logic w_la_done;

  assign w_up_done = (r_state == GNT_UP) && up.tvalid && m.tready && up.tlast;
  assign w_la_done = (r_state == GNT_LA) && la.tvalid && m.tready && la.tlast;

  assign grant      = r_grant;
  assign up_pkt_cnt = r_up_cnt;
  assign la_pkt_cnt = r_la_cnt;

  // Arbitration FSM: decides in IDLE, holds the grant until the granted packet's last beat.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state    <= IDLE;
      r_grant    <= 2'b00;
      r_last_la  <= 1'b1;
      r_hpri_gnt <= 1'b0;
      r_starve   <= '0;
      r_up_cnt   <= '0;
      r_la_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A user source that is not waiting cannot be starved.
          if (!up.tvalid) r_starve <= '0;
          if (arb_en) begin
            if (up.tvalid && (r_starve >= STARVE_MAX)) begin
              r_state    <= GNT_UP;
              r_grant    <= 2'b01;
              r_hpri_gnt <= 1'b0;
            end else if (la_hpri_req && la.tvalid && (r_starve < STARVE_MAX)) begin
              r_state    <= GNT_LA;
              r_grant    <= 2'b10;
              r_hpri_gnt <= 1'b1;
            end else if (up.tvalid && la.tvalid) begin
              r_hpri_gnt <= 1'b0;
              if (r_last_la) begin
                r_state <= GNT_UP;
                r_grant <= 2'b01;
              end else begin
                r_state <= GNT_LA;
                r_grant <= 2'b10;
              end
            end else if (up.tvalid) begin
              r_state    <= GNT_UP;
              r_grant    <= 2'b01;
              r_hpri_gnt <= 1'b0;
            end else if (la.tvalid) begin
              r_state    <= GNT_LA;
              r_grant    <= 2'b10;
              r_hpri_gnt <= 1'b0;
            end
          end
        end
        GNT_UP: begin
          if (w_up_done) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_last_la <= 1'b0;
            r_starve  <= '0;
            if (r_up_cnt != CNT_SAT) r_up_cnt <= r_up_cnt + 16'd1;
          end
        end
        GNT_LA: begin
          if (w_la_done) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_last_la <= 1'b1;
            if (r_la_cnt != CNT_SAT) r_la_cnt <= r_la_cnt + 16'd1;
            if (r_hpri_gnt && up.tvalid && (r_starve < STARVE_MAX))
              r_starve <= r_starve + STARVE_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  // Datapath mux: the granted source is wired straight through; IDLE drives all zeros.
  always_comb begin
    m.tdata  = '0;
    m.tstrb  = '0;
    m.tkeep  = '0;
    m.tuser  = '0;
    m.tlast  = 1'b0;
    m.tvalid = 1'b0;
    up.tready = 1'b0;
    la.tready = 1'b0;
    case (r_state)
      GNT_UP: begin
        m.tdata   = up.tdata;
        m.tstrb   = up.tstrb;
        m.tkeep   = up.tkeep;
        m.tuser   = up.tuser;
        m.tlast   = up.tlast;
        m.tvalid  = up.tvalid;
        up.tready = m.tready;
      end
      GNT_LA: begin
        m.tdata   = la.tdata;
        m.tstrb   = la.tstrb;
        m.tkeep   = la.tkeep;
        m.tuser   = la.tuser;
        m.tlast   = la.tlast;
        m.tvalid  = la.tvalid;
        la.tready = m.tready;
      end
      default: ;
    endcase
  end

endmodule
